// File: rtl/shift_unit_pipe.sv
// Two-stage pipelined shift/rotate unit with carry/zero flags and valid/ready
// handshaking on both sides; stage 1 shifts by the low amount bits, stage 2 by the rest.
module shift_unit_pipe #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   b,
    input  logic [2:0]       sfn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero
);

    localparam int LO = SHW / 2;
    localparam int HI = SHW - LO;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b011,
        OP_ROL = 3'b100,
        OP_ROR = 3'b101
    } op_e;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x,
                                              input logic [SHW-1:0]   n);
        logic [2*WIDTH-1:0] d;
        d = {x, x} << n;
        return d[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x,
                                              input logic [SHW-1:0]   n);
        logic [2*WIDTH-1:0] d;
        d = {x, x} >> n;
        return d[WIDTH-1:0];
    endfunction

    // Shifts run on a WIDTH+1 bit word carrying one guard bit, so the last bit
    // shifted out lands in the guard position (MSB for left, LSB for right).
    function automatic logic [WIDTH:0] shiftExt(input logic [WIDTH:0] ext,
                                                input logic [2:0]     op,
                                                input logic [SHW-1:0] amt);
        logic signed [WIDTH:0] sext;
        logic [WIDTH:0]        r;
        sext = ext;
        r    = '0;
        case (op)
            OP_SLL:  r = ext << amt;
            OP_SRL:  r = ext >> amt;
            OP_SRA:  r = sext >>> amt;
            OP_ROL:  r = {1'b0, rotl(ext[WIDTH-1:0], amt)};
            OP_ROR:  r = {1'b0, rotr(ext[WIDTH-1:0], amt)};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic             s1Valid_q, s1Valid_d;
    logic [WIDTH:0]   s1Ext_q,   s1Ext_d;
    logic [2:0]       s1Op_q,    s1Op_d;
    logic [HI-1:0]    s1Hi_q,    s1Hi_d;
    logic             s1BZero_q, s1BZero_d;
    logic             s2Valid_q, s2Valid_d;
    logic [WIDTH-1:0] y_q,       y_d;
    logic             carry_q,   carry_d;
    logic             zero_q,    zero_d;

    logic             s2Load;
    logic             s1Adv;
    logic             inFire;
    logic [WIDTH:0]   initExt;
    logic [SHW-1:0]   loAmt;
    logic [SHW-1:0]   hiAmt;
    logic [WIDTH:0]   ext2;
    logic [WIDTH-1:0] yRes;
    logic             carryRes;

    always_comb begin
        s2Load   = !s2Valid_q || out_ready;
        s1Adv    = s1Valid_q && s2Load;
        in_ready = !s1Valid_q || s2Load;
        inFire   = in_valid && in_ready;

        initExt = {1'b0, a};
        if (sfn == OP_SRL || sfn == OP_SRA) begin
            initExt = {a, 1'b0};
        end
        loAmt = {{HI{1'b0}}, b[LO-1:0]};
        hiAmt = {s1Hi_q, {LO{1'b0}}};
        ext2  = shiftExt(s1Ext_q, s1Op_q, hiAmt);

        yRes     = '0;
        carryRes = 1'b0;
        case (s1Op_q)
            OP_SLL: begin
                yRes     = ext2[WIDTH-1:0];
                carryRes = ext2[WIDTH];
            end
            OP_SRL, OP_SRA: begin
                yRes     = ext2[WIDTH:1];
                carryRes = ext2[0];
            end
            OP_ROL: begin
                yRes     = ext2[WIDTH-1:0];
                carryRes = !s1BZero_q && ext2[0];
            end
            OP_ROR: begin
                yRes     = ext2[WIDTH-1:0];
                carryRes = !s1BZero_q && ext2[WIDTH-1];
            end
            default: begin
                yRes     = '0;
                carryRes = 1'b0;
            end
        endcase
    end

    // A stage refills when empty or when its contents leave in the same cycle.
    always_comb begin
        s1Valid_d = s1Valid_q;
        s1Ext_d   = s1Ext_q;
        s1Op_d    = s1Op_q;
        s1Hi_d    = s1Hi_q;
        s1BZero_d = s1BZero_q;
        s2Valid_d = s2Valid_q;
        y_d       = y_q;
        carry_d   = carry_q;
        zero_d    = zero_q;

        if (inFire) begin
            s1Valid_d = 1'b1;
            s1Ext_d   = shiftExt(initExt, sfn, loAmt);
            s1Op_d    = sfn;
            s1Hi_d    = b[SHW-1:LO];
            s1BZero_d = (b == '0);
        end else if (s1Adv) begin
            s1Valid_d = 1'b0;
        end

        if (s2Load) begin
            s2Valid_d = s1Valid_q;
        end
        if (s1Adv) begin
            y_d     = yRes;
            carry_d = carryRes;
            zero_d  = (yRes == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1Valid_q <= 1'b0;
            s1Ext_q   <= '0;
            s1Op_q    <= '0;
            s1Hi_q    <= '0;
            s1BZero_q <= 1'b0;
            s2Valid_q <= 1'b0;
            y_q       <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1Ext_q   <= s1Ext_d;
            s1Op_q    <= s1Op_d;
            s1Hi_q    <= s1Hi_d;
            s1BZero_q <= s1BZero_d;
            s2Valid_q <= s2Valid_d;
            y_q       <= y_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
        end
    end

    assign out_valid = s2Valid_q;
    assign y         = y_q;
    assign carry     = carry_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe (WIDTH=32): directed vectors, streaming,
// backpressure, mid-flight reset and a random run against a scoreboard.
module tb_shift_unit_pipe;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [4:0]    b;
    logic [2:0]    sfn;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic          carry;
    logic          zero;

    shift_unit_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sfn       (sfn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .carry     (carry),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [4:0]   b;
        logic [2:0]   f;
        logic [W-1:0] y;
        logic         c;
    } dirVec_t;

    int           vectors = 0;
    int           miscompares = 0;
    int           inFires = 0;
    int           outFires = 0;
    logic [W+1:0] sbQ[$];
    logic         heldValid = 1'b0;
    logic [W+1:0] heldVal = '0;
    dirVec_t      dirTab[$];

    // Behavioural reference written directly from the opcode and carry rules.
    function automatic logic [W+1:0] refOp(input logic [W-1:0] av,
                                           input logic [4:0]   bv,
                                           input logic [2:0]   fv);
        int           bi;
        logic [W-1:0] r;
        logic         c;
        bi = int'(bv);
        r  = '0;
        c  = 1'b0;
        case (fv)
            3'b000: begin r = av << bi;                  if (bi != 0) c = av[W-bi]; end
            3'b001: begin r = av >> bi;                  if (bi != 0) c = av[bi-1]; end
            3'b011: begin r = $signed(av) >>> bi;        if (bi != 0) c = av[bi-1]; end
            3'b100: begin r = (bi == 0) ? av : ((av << bi) | (av >> (W - bi))); if (bi != 0) c = r[0]; end
            3'b101: begin r = (bi == 0) ? av : ((av >> bi) | (av << (W - bi))); if (bi != 0) c = r[W-1]; end
            default: begin r = '0; c = 1'b0; end
        endcase
        return {r, c, (r == '0)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive at negedge, sample #1 later, push/pop scoreboard.
    task automatic applyStimulus(input bit v, input logic [W-1:0] av, input logic [4:0] bv,
                                 input logic [2:0] fv, input bit ordy,
                                 input bit useExp, input logic [W+1:0] expVal);
        logic [W+1:0] e;
        in_valid  = v;
        a         = av;
        b         = bv;
        sfn       = fv;
        out_ready = ordy;
        #1;
        if (heldValid) begin
            checkOutput("hold_valid", 64'(out_valid), 64'(1'b1));
            checkOutput("hold_data", 64'({y, carry, zero}), 64'(heldVal));
        end
        heldValid = out_valid && !out_ready;
        heldVal   = {y, carry, zero};
        if (out_valid && out_ready) begin
            outFires++;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_out", 64'(out_valid), 64'(1'b0));
            end else begin
                e = sbQ.pop_front();
                checkOutput("result", 64'({y, carry, zero}), 64'(e));
            end
        end
        if (in_valid && in_ready) begin
            inFires++;
            sbQ.push_back(useExp ? expVal : refOp(av, bv, fv));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        applyStimulus(1'b0, '0, '0, '0, ordy, 1'b0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int inBase;
        int outBase;
        dirVec_t dv;

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sfn       = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'(1'b0));
        checkOutput("reset_y", 64'(y), 64'(0));
        checkOutput("reset_flags", 64'({carry, zero}), 64'(0));
        checkOutput("reset_in_ready", 64'(in_ready), 64'(1'b1));

        // Latency: result appears two edges after the op is presented.
        applyStimulus(1'b1, 32'h0000_00F1, 5'd4, 3'b000, 1'b1, 1'b1, {32'h0000_0F10, 1'b0, 1'b0});
        in_valid = 1'b0;
        #1;
        checkOutput("latency_edge1", 64'(out_valid), 64'(1'b0));
        idle(1'b1);
        checkOutput("latency_edge2", 64'(out_valid), 64'(1'b1));
        idle(1'b1);

        dirTab.push_back('{a: 32'h8000_0000, b: 5'd1,  f: 3'b000, y: 32'h0000_0000, c: 1'b1});
        dirTab.push_back('{a: 32'h8000_0010, b: 5'd5,  f: 3'b011, y: 32'hFC00_0000, c: 1'b1});
        dirTab.push_back('{a: 32'h8000_0010, b: 5'd5,  f: 3'b001, y: 32'h0400_0000, c: 1'b1});
        dirTab.push_back('{a: 32'h0000_0001, b: 5'd1,  f: 3'b101, y: 32'h8000_0000, c: 1'b1});
        dirTab.push_back('{a: 32'h8000_0001, b: 5'd4,  f: 3'b100, y: 32'h0000_0018, c: 1'b0});
        dirTab.push_back('{a: 32'hA5A5_F00F, b: 5'd0,  f: 3'b000, y: 32'hA5A5_F00F, c: 1'b0});
        dirTab.push_back('{a: 32'hA5A5_F00F, b: 5'd0,  f: 3'b001, y: 32'hA5A5_F00F, c: 1'b0});
        dirTab.push_back('{a: 32'hA5A5_F00F, b: 5'd0,  f: 3'b011, y: 32'hA5A5_F00F, c: 1'b0});
        dirTab.push_back('{a: 32'hA5A5_F00F, b: 5'd0,  f: 3'b100, y: 32'hA5A5_F00F, c: 1'b0});
        dirTab.push_back('{a: 32'hA5A5_F00F, b: 5'd0,  f: 3'b101, y: 32'hA5A5_F00F, c: 1'b0});
        dirTab.push_back('{a: 32'h1234_5678, b: 5'd3,  f: 3'b110, y: 32'h0000_0000, c: 1'b0});
        dirTab.push_back('{a: 32'hFFFF_FFFF, b: 5'd3,  f: 3'b010, y: 32'h0000_0000, c: 1'b0});
        dirTab.push_back('{a: 32'hFFFF_FFFF, b: 5'd9,  f: 3'b111, y: 32'h0000_0000, c: 1'b0});
        dirTab.push_back('{a: 32'hFFFF_FFFF, b: 5'd31, f: 3'b001, y: 32'h0000_0001, c: 1'b1});
        dirTab.push_back('{a: 32'h0000_0001, b: 5'd31, f: 3'b000, y: 32'h8000_0000, c: 1'b0});
        dirTab.push_back('{a: 32'h7FFF_FFFF, b: 5'd31, f: 3'b011, y: 32'h0000_0000, c: 1'b1});
        dirTab.push_back('{a: 32'h8000_0000, b: 5'd31, f: 3'b011, y: 32'hFFFF_FFFF, c: 1'b0});
        dirTab.push_back('{a: 32'h0000_0002, b: 5'd31, f: 3'b101, y: 32'h0000_0004, c: 1'b0});
        dirTab.push_back('{a: 32'h0000_0001, b: 5'd31, f: 3'b100, y: 32'h8000_0000, c: 1'b0});
        foreach (dirTab[i]) begin
            dv = dirTab[i];
            applyStimulus(1'b1, dv.a, dv.b, dv.f, 1'b1, 1'b1, {dv.y, dv.c, (dv.y == '0)});
        end
        repeat (3) idle(1'b1);
        checkOutput("directed_drained", 64'(sbQ.size()), 64'(0));

        // Eight back-to-back operations must stream out on consecutive cycles.
        inBase  = inFires;
        outBase = outFires;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, W'($urandom()), 5'($urandom_range(0, 31)),
                          3'($urandom_range(0, 7)), 1'b1, 1'b0, '0);
        end
        repeat (2) idle(1'b1);
        checkOutput("stream_accepts", 64'(inFires - inBase), 64'(8));
        checkOutput("stream_results", 64'(outFires - outBase), 64'(8));

        // Backpressure: only two operations fit, then in_ready drops.
        inBase  = inFires;
        outBase = outFires;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, W'($urandom()), 5'($urandom_range(0, 31)),
                          3'($urandom_range(0, 7)), 1'b0, 1'b0, '0);
        end
        #1;
        checkOutput("bp_accepts", 64'(inFires - inBase), 64'(2));
        checkOutput("bp_in_ready", 64'(in_ready), 64'(1'b0));
        repeat (3) idle(1'b1);
        checkOutput("bp_released", 64'(outFires - outBase), 64'(2));

        // Reset with two operations in flight discards both.
        applyStimulus(1'b1, 32'h0000_0F0F, 5'd2, 3'b000, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 32'h0000_00FF, 5'd1, 3'b001, 1'b0, 1'b0, '0);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sbQ.delete();
        heldValid = 1'b0;
        #1;
        checkOutput("rst_mid_out_valid", 64'(out_valid), 64'(1'b0));
        checkOutput("rst_mid_in_ready", 64'(in_ready), 64'(1'b1));
        outBase = outFires;
        repeat (4) idle(1'b1);
        checkOutput("rst_mid_no_output", 64'(outFires - outBase), 64'(0));

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), W'($urandom()), 5'($urandom_range(0, 31)),
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), 1'b0, '0);
        end
        for (int i = 0; i < 20 && sbQ.size() != 0; i++) begin
            idle(1'b1);
        end
        checkOutput("random_drained", 64'(sbQ.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
